// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Grants a latched byte, then waits for a synchronized donetx edge or a timeout and a quiet gap.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 40000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       send,
    output logic [7:0]                 dintx,
    input  logic                       donetx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state, state_n;
    logic [ID_W-1:0]    last, last_n, grant_n;
    logic [7:0]         dintx_n;
    logic               send_n, busy_n;
    logic [NUM_REQ-1:0] ack_n, done_n, err_n;
    logic [TMO_W-1:0]   tmo_cnt, tmo_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic               sync_m, sync_q, sync_qq;
    logic               done_rise;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id, cand;
    logic [7:0]         pick_byte;

    assign done_rise = sync_q & ~sync_qq;
    assign pick_byte = req_data[{pick_id, 3'b000} +: 8];

    // First requesting index after the last owner, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = last;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Next-state and next-output logic; every registered value holds unless changed here.
    always_comb begin
        state_n = state;
        last_n  = last;
        grant_n = grant_id;
        dintx_n = dintx;
        send_n  = send;
        ack_n   = '0;
        done_n  = '0;
        err_n   = '0;
        tmo_n   = tmo_cnt;
        gap_n   = gap_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = SEND;
                    last_n  = pick_id;
                    grant_n = pick_id;
                    dintx_n = pick_byte;
                    ack_n   = NUM_REQ'(1) << pick_id;
                    send_n  = 1'b1;
                    tmo_n   = '0;
                end
            end
            SEND: begin
                tmo_n = tmo_cnt + 1'b1;
                // A completion seen on the final timeout cycle still counts as success.
                if (done_rise) begin
                    send_n  = 1'b0;
                    done_n  = NUM_REQ'(1) << grant_id;
                    gap_n   = '0;
                    state_n = GAP;
                end else if (tmo_cnt == TMO_LAST) begin
                    send_n  = 1'b0;
                    err_n   = NUM_REQ'(1) << grant_id;
                    gap_n   = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                // Leave only after the minimum gap and once donetx has fallen again.
                if (gap_cnt >= GAP_MIN && !sync_qq) begin
                    state_n = IDLE;
                end else if (gap_cnt < GAP_MIN) begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= ID_W'(NUM_REQ - 1);
            grant_id <= '0;
            dintx    <= 8'h00;
            send     <= 1'b0;
            busy     <= 1'b0;
            req_ack  <= '0;
            req_done <= '0;
            req_err  <= '0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
            sync_m   <= 1'b0;
            sync_q   <= 1'b0;
            sync_qq  <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            grant_id <= grant_n;
            dintx    <= dintx_n;
            send     <= send_n;
            busy     <= busy_n;
            req_ack  <= ack_n;
            req_done <= done_n;
            req_err  <= err_n;
            tmo_cnt  <= tmo_n;
            gap_cnt  <= gap_n;
            sync_m   <= donetx;
            sync_q   <= sync_m;
            sync_qq  <= sync_q;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a round-robin reference model queues the expected
// ack/done/err sequence, and a monitor checks every pulse the arbiter emits against it.
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int GAP      = 4;
    localparam int TMO      = 500;
    localparam int DONE_DLY = 100;
    localparam int DONE_LEN = 20;
    localparam int K_ACK    = 0;
    localparam int K_DONE   = 1;
    localparam int K_ERR    = 2;

    typedef struct {
        int         kind;
        int         id;
        logic [7:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_ack, req_done, req_err;
    logic            send, busy, donetx;
    logic [7:0]      dintx;
    logic [1:0]      grant_id;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         ack_cyc = 0;
    bit         stub_never = 1'b0;
    exp_t       sb[$];
    int         m_last;
    logic [7:0] m_data [NR];

    uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
        .send(send), .dintx(dintx), .donetx(donetx), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int last_i);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last_i + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Transmitter stub: donetx rises DONE_DLY cycles after send rises and stays high DONE_LEN cycles.
    always @(negedge clk) begin : stub
        int dly;
        int hold;
        bit send_q;
        if (!rst) begin
            dly = 0; hold = 0; send_q = 1'b0; donetx = 1'b0;
        end else begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) donetx = 1'b0;
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    donetx = 1'b1; hold = DONE_LEN; rise_cyc = cyc;
                end
            end
            if (send && !send_q && !stub_never) dly = DONE_DLY;
            send_q = send;
        end
    end

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        logic [NR-1:0] p;
        exp_t e;
        int kind;
        int id;
        if (rst) begin
            p = req_ack | req_done | req_err;
            if (p != '0) begin
                chk("single_pulse", $countones(req_ack) + $countones(req_done) + $countones(req_err), 1);
                kind = (req_ack != '0) ? K_ACK : (req_done != '0) ? K_DONE : K_ERR;
                id = 0;
                for (int i = NR - 1; i >= 0; i--) if (p[i]) id = i;
                chk("event_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("kind", kind, e.kind);
                    chk("owner", id, e.id);
                    chk("grant_id", int'(grant_id), e.id);
                    chk("dintx", int'(dintx), int'(e.data));
                    chk("busy", int'(busy), 1);
                    if (kind == K_ACK) begin
                        chk("send_at_ack", int'(send), 1);
                        ack_cyc = cyc;
                    end else if (kind == K_DONE) begin
                        chk("send_at_done", int'(send), 0);
                        chk("done_latency", cyc - rise_cyc, 3);
                    end else begin
                        chk("send_at_err", int'(send), 0);
                        chk("err_latency", cyc - ack_cyc, TMO);
                    end
                end
            end
        end
    end

    task automatic set_data(input int i, input logic [7:0] b);
        m_data[i] = b;
        req_data[8*i +: 8] = b;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ack == '0 && n < 2000);
        chk("ack_seen", int'(req_ack != '0), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    // Hold pattern v for k frames; each owner loads a fresh byte after its ack, all drop after the last.
    task automatic run_phase(input logic [NR-1:0] v, input int k, input bit never);
        exp_t e;
        int w;
        int who[$];
        logic [7:0] nxt[$];
        logic [7:0] b;
        stub_never = never;
        for (int j = 0; j < k; j++) begin
            w = rr_pick(v, m_last);
            m_last = w;
            e.kind = K_ACK; e.id = w; e.data = m_data[w];
            sb.push_back(e);
            e.kind = never ? K_ERR : K_DONE;
            sb.push_back(e);
            b = 8'($urandom);
            m_data[w] = b;
            who.push_back(w);
            nxt.push_back(b);
        end
        req_valid = v;
        for (int j = 0; j < k; j++) begin
            wait_ack();
            @(posedge clk);
            #1;
            req_data[8*who[j] +: 8] = nxt[j];
            if (j == k - 1) req_valid = '0;
        end
        drain();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_drop", int'(busy), 0);
    endtask

    task automatic reset_mid();
        exp_t e;
        stub_never = 1'b0;
        set_data(0, 8'($urandom_range(1, 255)));
        e.kind = K_ACK; e.id = rr_pick(4'b0001, m_last); e.data = m_data[0];
        sb.push_back(e);
        req_valid = 4'b0001;
        wait_ack();
        req_valid = '0;
        repeat (10) @(negedge clk);
        chk("send_before_rst", int'(send), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_send", int'(send), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_dintx", int'(dintx), 0);
        sb.delete();
        m_last = NR - 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] v;
        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        m_last = NR - 1;
        for (int i = 0; i < NR; i++) set_data(i, 8'($urandom));
        repeat (3) @(negedge clk);
        chk("rst_send", int'(send), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dintx", int'(dintx), 0);
        chk("rst_pulses", int'(req_ack | req_done | req_err), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        rst = 1'b1;
        @(negedge clk);

        set_data(2, 8'hA5);
        run_phase(4'b0100, 1, 1'b0);
        wait_idle();

        reset_mid();
        run_phase(4'b1010, 1, 1'b0);
        run_phase(4'b0011, 2, 1'b0);
        run_phase(4'b1111, 5, 1'b0);

        for (int r = 0; r < 8; r++) begin
            v = NR'($urandom_range(1, 15));
            run_phase(v, int'($urandom_range(1, 4)), 1'b0);
        end

        v = 4'b0001 << $urandom_range(0, 3);
        run_phase(v, 1, 1'b1);
        run_phase(4'b0110, 2, 1'b0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
